sram_march_bist: RTL and testbench
==================================

// Module: sram_march_bist
// PURPOSE
//  Built-in self-test sequencer for the OpenRAM test-chip macros. It drives the shared SRAM
//  control/data bus (addr0/din0/web0/wmask0/csb0, addr1/csb1) for one selected macro and
//  runs a 4-element March test. It compares the returned read data and records the error count
//  and the first failing address and data. It sits beside the scan-chain control logic; a wrapper
//  mux gives it the bus when busy=1.
// PARAMETERS
//  ADDR_W     16  address width (matches shared addr0/addr1)
//  DATA_W     32  data width (din0/dout)
//  WMASK_W    4   byte write-mask width
//  MAX_CHIPS  16  number of per-macro chip selects
//  RD_LAT     1   cycles from read command (csb low, web high) to valid rdata (1..4)
// PORTS
//  clk             in   1          clock
//  rstn            in   1          synchronous active-low reset
//  start           in   1          begin test (sampled in IDLE only)
//  abort           in   1          terminate running test
//  chip_sel        in   4          index of macro under test (< MAX_CHIPS)
//  last_addr       in   ADDR_W     highest address tested (N = last_addr+1)
//  pattern         in   DATA_W     background data P (complement ~P also used)
//  use_port1       in   1          1: element M3 reads through port 1
//  rdata0          in   DATA_W     dout0 of selected macro
//  rdata1          in   DATA_W     dout1 of selected macro
//  csb0/csb1       out  MAX_CHIPS  active-low chip selects, one-hot-low on chip_sel
//  web0            out  1          0 = write
//  wmask0          out  WMASK_W    all ones during writes
//  addr0/addr1     out  ADDR_W     port addresses
//  din0            out  DATA_W     write data
//  busy            out  1          test running (including drain)
//  done            out  1          test completed (level, cleared by next accepted start)
//  fail            out  1          err_count != 0
//  err_count       out  16         mismatching reads, saturates at 16'hFFFF
//  first_fail_addr out  ADDR_W     address of first mismatch
//  first_fail_data out  DATA_W     rdata captured at first mismatch
// BEHAVIOUR
//  Reset: csb0=csb1=all ones, web0=1, wmask0=0, addr*=0, din0=0, busy=done=fail=0,
//   err_count=0, first_fail_*=0, and the compare pipeline is emptied. All outputs are registered.
//  FSM: IDLE -> M0_W -> M1_R -> M1_W -> M2_R -> M2_W -> M3_R -> DRAIN -> IDLE.
//  IDLE & start: latch chip_sel, last_addr, pattern and use_port1; clear the error state and done;
//   set busy=1. The first command appears in the next cycle.
//  M0 (addr 0..N-1, ascending): write P.
//  M1 (ascending): read expecting P, then write ~P to the same address.
//  M2 (descending N-1..0): read expecting ~P, then write P.
//  M3 (descending): read expecting P. If use_port1=1 the read uses csb1/addr1 and rdata1, and
//   csb0 stays all ones.
//  One command per cycle, so the test issues 6N commands. Outside a command, all csb are high.
//  Address counter: no wrap. An element ends at last_addr (ascending) or 0 (descending).
//   When last_addr=0, each element is one address.
//  Compare pipeline: each read pushes {valid, port, addr, expected} into an RD_LAT-deep shift
//   register. When the entry emerges, rdata(port) is compared with expected.
//   On mismatch: err_count+1 (saturating). If this is the first error, capture
//   first_fail_addr and first_fail_data.
//  DRAIN: RD_LAT idle cycles after the last M3 read. Then, in one cycle: busy=0, done=1, state=IDLE.
//  abort while busy: next cycle state=IDLE, all csb high, busy=0, done=0, pipeline flushed.
//   Error state is held until the next start.
//  start while busy: ignored. abort in IDLE: no effect.
//  rstn low at any time, including mid-element: full reset next edge; no partial write
//   command persists.
// TESTING
//  1 Ideal memory model, RD_LAT=1, last_addr=3, P=32'hA5A5A5A5 -> 24 command cycles in
//    M0..M3 order, done=1, fail=0, err_count=0.
//  2 Model bit0 stuck-at-0 at addr 2, same setup -> err_count=2 (M1 and M3 reads),
//    first_fail_addr=2, first_fail_data=32'hA5A5A5A4.
//  3 last_addr=0 -> exact command sequence W(P), R(P), W(~P), R(~P), W(P), R(P) at addr 0,
//    done RD_LAT+1 cycles after the final read.
//  4 abort during M2 -> next cycle csb all ones, busy=0, done=0. A restart clears err_count
//    and completes cleanly.
//  5 start pulsed while busy -> no effect. rstn low mid-M1 -> all outputs at reset values
//    next cycle.
//  6 use_port1=1, chip_sel=4 -> M3 reads drive csb1=16'hFFEF and addr1; csb0 stays all ones
//    in M3. A port-1-only fault is counted.

Source files
------------

// File: rtl/sram_march_bist.sv
// March BIST sequencer for one OpenRAM macro on the shared SRAM bus.
// Runs M0..M3, compares read data, and records the error count and first failure.
module sram_march_bist #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int WMASK_W   = 4,
  parameter int MAX_CHIPS = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           chip_sel,
  input  logic [ADDR_W-1:0]    last_addr,
  input  logic [DATA_W-1:0]    pattern,
  input  logic                 use_port1,
  input  logic [DATA_W-1:0]    rdata0,
  input  logic [DATA_W-1:0]    rdata1,
  output logic [MAX_CHIPS-1:0] csb0,
  output logic [MAX_CHIPS-1:0] csb1,
  output logic                 web0,
  output logic [WMASK_W-1:0]   wmask0,
  output logic [ADDR_W-1:0]    addr0,
  output logic [ADDR_W-1:0]    addr1,
  output logic [DATA_W-1:0]    din0,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [15:0]          err_count,
  output logic [ADDR_W-1:0]    first_fail_addr,
  output logic [DATA_W-1:0]    first_fail_data
);

  typedef enum logic [2:0] {
    IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, DRAIN
  } state_t;

  state_t state, n_state;

  logic [ADDR_W-1:0] cnt, n_cnt, last_q;
  logic [2:0]        dcnt, n_dcnt;
  logic [3:0]        sel_q, a_sel;
  logic [DATA_W-1:0] pat_q, a_pat;
  logic              p1_q, a_p1;
  logic              go, kill;
  logic              n_busy, n_done;

  logic [MAX_CHIPS-1:0] oh;
  logic [MAX_CHIPS-1:0] n_csb0, n_csb1;
  logic                 n_web0;
  logic [WMASK_W-1:0]   n_wmask0;
  logic [ADDR_W-1:0]    n_addr0, n_addr1;
  logic [DATA_W-1:0]    n_din0;

  logic              pv [RD_LAT];
  logic              pp [RD_LAT];
  logic [ADDR_W-1:0] pa [RD_LAT];
  logic [DATA_W-1:0] pe [RD_LAT];

  logic              push, push_p, chk, mis;
  logic [DATA_W-1:0] push_e, rd;
  logic [15:0]       n_err;
  logic [ADDR_W-1:0] n_ffa;
  logic [DATA_W-1:0] n_ffd;

  assign go   = (state == IDLE) && start;
  assign kill = busy && abort;

  // The first command uses the inputs being latched on the same edge.
  assign a_sel = go ? chip_sel  : sel_q;
  assign a_pat = go ? pattern   : pat_q;
  assign a_p1  = go ? use_port1 : p1_q;
  assign oh    = ~(MAX_CHIPS'(1) << a_sel);

  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_dcnt  = dcnt;
    n_busy  = busy;
    n_done  = done;
    if (kill) begin
      n_state = IDLE;
      n_busy  = 1'b0;
      n_done  = 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_state = M0_W;
          n_cnt   = '0;
          n_busy  = 1'b1;
          n_done  = 1'b0;
        end
        M0_W: if (cnt == last_q) begin
          n_state = M1_R;
          n_cnt   = '0;
        end else begin
          n_cnt = cnt + 1'b1;
        end
        M1_R: n_state = M1_W;
        M1_W: if (cnt == last_q) begin
          n_state = M2_R;
        end else begin
          n_state = M1_R;
          n_cnt   = cnt + 1'b1;
        end
        M2_R: n_state = M2_W;
        M2_W: if (cnt == '0) begin
          n_state = M3_R;
          n_cnt   = last_q;
        end else begin
          n_state = M2_R;
          n_cnt   = cnt - 1'b1;
        end
        M3_R: if (cnt == '0) begin
          n_state = DRAIN;
          n_dcnt  = 3'(RD_LAT - 1);
        end else begin
          n_cnt = cnt - 1'b1;
        end
        DRAIN: if (dcnt == '0) begin
          n_state = IDLE;
          n_busy  = 1'b0;
          n_done  = 1'b1;
        end else begin
          n_dcnt = dcnt - 1'b1;
        end
        default: n_state = IDLE;
      endcase
    end
  end

  // Bus outputs are registered from the next command; idle cycles keep addr/data.
  always_comb begin
    n_csb0   = '1;
    n_csb1   = '1;
    n_web0   = 1'b1;
    n_wmask0 = '0;
    n_addr0  = addr0;
    n_addr1  = addr1;
    n_din0   = din0;
    case (n_state)
      M0_W, M2_W, M1_W: begin
        n_csb0   = oh;
        n_web0   = 1'b0;
        n_wmask0 = '1;
        n_addr0  = n_cnt;
        n_din0   = (n_state == M1_W) ? ~a_pat : a_pat;
      end
      M1_R, M2_R: begin
        n_csb0  = oh;
        n_addr0 = n_cnt;
      end
      M3_R: if (a_p1) begin
        n_csb1  = oh;
        n_addr1 = n_cnt;
      end else begin
        n_csb0  = oh;
        n_addr0 = n_cnt;
      end
      default: ;
    endcase
  end

  assign push   = (state == M1_R) || (state == M2_R) || (state == M3_R);
  assign push_p = (state == M3_R) && p1_q;
  assign push_e = (state == M2_R) ? ~pat_q : pat_q;
  assign chk    = pv[RD_LAT-1];
  assign rd     = pp[RD_LAT-1] ? rdata1 : rdata0;
  assign mis    = chk && (rd != pe[RD_LAT-1]);

  always_comb begin
    n_err = err_count;
    n_ffa = first_fail_addr;
    n_ffd = first_fail_data;
    if (go) begin
      n_err = '0;
      n_ffa = '0;
      n_ffd = '0;
    end else if (mis && !kill) begin
      if (err_count != 16'hFFFF) n_err = err_count + 16'd1;
      if (err_count == '0) begin
        n_ffa = pa[RD_LAT-1];
        n_ffd = rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      cnt             <= '0;
      dcnt            <= '0;
      last_q          <= '0;
      sel_q           <= '0;
      pat_q           <= '0;
      p1_q            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
      csb0            <= '1;
      csb1            <= '1;
      web0            <= 1'b1;
      wmask0          <= '0;
      addr0           <= '0;
      addr1           <= '0;
      din0            <= '0;
    end else begin
      state           <= n_state;
      cnt             <= n_cnt;
      dcnt            <= n_dcnt;
      busy            <= n_busy;
      done            <= n_done;
      fail            <= (n_err != '0);
      err_count       <= n_err;
      first_fail_addr <= n_ffa;
      first_fail_data <= n_ffd;
      csb0            <= n_csb0;
      csb1            <= n_csb1;
      web0            <= n_web0;
      wmask0          <= n_wmask0;
      addr0           <= n_addr0;
      addr1           <= n_addr1;
      din0            <= n_din0;
      if (go) begin
        last_q <= last_addr;
        sel_q  <= chip_sel;
        pat_q  <= pattern;
        p1_q   <= use_port1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || kill) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pp[i] <= 1'b0;
        pa[i] <= '0;
        pe[i] <= '0;
      end
    end else begin
      pv[0] <= push;
      pp[0] <= push_p;
      pa[0] <= cnt;
      pe[0] <= push_e;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
        pa[i] <= pa[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist: memory model with fault hooks,
// expected bus commands queued by stimulus and popped by a negedge monitor.
module tb_sram_march_bist;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          use_port1 = 1'b0;
  logic [3:0]    chip_sel = '0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] pattern = '0;
  logic [DW-1:0] rdata0 = '0;
  logic [DW-1:0] rdata1 = '0;
  logic [15:0]   csb0, csb1;
  logic          web0;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;
  logic          busy, done, fail;
  logic [15:0]   err_count;
  logic [AW-1:0] first_fail_addr;
  logic [DW-1:0] first_fail_data;

  sram_march_bist #(
    .ADDR_W(AW), .DATA_W(DW), .WMASK_W(4),
    .MAX_CHIPS(16), .RD_LAT(1)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .chip_sel(chip_sel), .last_addr(last_addr),
    .pattern(pattern), .use_port1(use_port1),
    .rdata0(rdata0), .rdata1(rdata1),
    .csb0(csb0), .csb1(csb1), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .addr1(addr1), .din0(din0),
    .busy(busy), .done(done), .fail(fail),
    .err_count(err_count),
    .first_fail_addr(first_fail_addr),
    .first_fail_data(first_fail_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [0:255];
  int sel_tb = 0;
  int stuck_addr = -1;
  int p1_addr = -1;

  function automatic logic [DW-1:0] rd_word(logic [AW-1:0] a, bit p1);
    logic [DW-1:0] d;
    d = mem[a[7:0]];
    if (int'(a) == stuck_addr) d[0] = 1'b0;
    if (p1 && int'(a) == p1_addr) d[5] = ~d[5];
    return d;
  endfunction

  always @(posedge clk) begin
    if (!csb0[sel_tb]) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) mem[addr0[7:0]][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        rdata0 <= rd_word(addr0, 1'b0);
      end
    end
    if (!csb1[sel_tb]) rdata1 <= rd_word(addr1, 1'b1);
  end

  typedef struct packed {
    logic [15:0] csb0;
    logic [15:0] csb1;
    logic        web;
    logic [3:0]  wm;
    logic [15:0] addr;
    logic [31:0] din;
  } cmd_t;

  cmd_t exp_q[$];
  int cmd_cnt = 0;
  int last_cmd_cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  function automatic cmd_t mk(logic [15:0] c0, logic [15:0] c1,
                              logic w, int a, logic [31:0] d);
    cmd_t c;
    c.csb0 = c0;
    c.csb1 = c1;
    c.web  = w;
    c.wm   = w ? 4'h0 : 4'hF;
    c.addr = 16'(a);
    c.din  = w ? 32'h0 : d;
    return c;
  endfunction

  task automatic push_march(int last, logic [31:0] p,
                            logic [3:0] sel, bit p1);
    logic [15:0] oh;
    oh = ~(16'h1 << sel);
    for (int a = 0; a <= last; a++)
      exp_q.push_back(mk(oh, 16'hFFFF, 1'b0, a, p));
    for (int a = 0; a <= last; a++) begin
      exp_q.push_back(mk(oh, 16'hFFFF, 1'b1, a, 32'h0));
      exp_q.push_back(mk(oh, 16'hFFFF, 1'b0, a, ~p));
    end
    for (int a = last; a >= 0; a--) begin
      exp_q.push_back(mk(oh, 16'hFFFF, 1'b1, a, 32'h0));
      exp_q.push_back(mk(oh, 16'hFFFF, 1'b0, a, p));
    end
    for (int a = last; a >= 0; a--)
      if (p1) exp_q.push_back(mk(16'hFFFF, oh, 1'b1, a, 32'h0));
      else    exp_q.push_back(mk(oh, 16'hFFFF, 1'b1, a, 32'h0));
  endtask

  always @(negedge clk) begin
    cmd_t act, e;
    if (csb0 !== 16'hFFFF || csb1 !== 16'hFFFF) begin
      act.csb0 = csb0;
      act.csb1 = csb1;
      act.web  = web0;
      act.wm   = web0 ? 4'h0 : wmask0;
      act.addr = (csb1 !== 16'hFFFF) ? addr1 : addr0;
      act.din  = web0 ? 32'h0 : din0;
      cmd_cnt++;
      last_cmd_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_unexpected: got %h, expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL cmd_%0d: got %h, expected %h", cmd_cnt, act, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic go(int last, logic [31:0] p, logic [3:0] sel, bit p1);
    @(negedge clk);
    last_addr = 16'(last);
    pattern   = p;
    chip_sel  = sel;
    use_port1 = p1;
    sel_tb    = int'(sel);
    start     = 1'b1;
    push_march(last, p, sel, p1);
    @(negedge clk);
    start     = 1'b0;
    last_addr = 16'h00FF;
    pattern   = 32'hDEADBEEF;
    chip_sel  = 4'hF;
    use_port1 = ~p1;
    chk("first_cmd", {busy, csb0}, {1'b1, ~(16'h1 << sel)});
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 400; k++) begin
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (dc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done=%b, expected 1", done);
    end
  endtask

  task automatic wait_cmds(int base, int n);
    for (int k = 0; k < 200; k++) begin
      if (cmd_cnt - base >= n) return;
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL cmd_timeout: got %0d, expected %0d", cmd_cnt - base, n);
  endtask

  initial begin
    int base, dc;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_csb", {csb0, csb1}, 32'hFFFFFFFF);
    chk("rst_ctl", {web0, wmask0, busy, done, fail}, 8'b1000_0000);
    chk("rst_bus", {addr0, addr1, din0}, 64'h0);
    chk("rst_err", {err_count, first_fail_addr, first_fail_data}, 64'h0);
    rstn = 1'b1;

    // clean run, N=4
    base = cmd_cnt;
    go(3, 32'hA5A5A5A5, 4'd0, 1'b0);
    wait_done(dc);
    chk("t1_cmds", 64'(cmd_cnt - base), 64'd24);
    chk("t1_queue", 64'(exp_q.size()), 64'd0);
    chk("t1_res", {busy, done, fail, err_count}, {3'b010, 16'd0});

    // bit0 stuck-at-0 at addr 2
    stuck_addr = 2;
    go(3, 32'hA5A5A5A5, 4'd0, 1'b0);
    wait_done(dc);
    stuck_addr = -1;
    chk("t2_err", {done, fail, err_count}, {2'b11, 16'd2});
    chk("t2_ffa", first_fail_addr, 16'd2);
    chk("t2_ffd", first_fail_data, 32'hA5A5A5A4);

    // single address, done timing
    base = cmd_cnt;
    go(0, 32'h0F0F1234, 4'd1, 1'b0);
    wait_done(dc);
    chk("t3_cmds", 64'(cmd_cnt - base), 64'd6);
    chk("t3_done_lat", 64'(dc - last_cmd_cyc), 64'd2);
    chk("t3_res", {fail, err_count}, 17'd0);

    // abort during M2 with one error recorded in M1
    stuck_addr = 2;
    base = cmd_cnt;
    go(3, 32'hA5A5A5A5, 4'd0, 1'b0);
    wait_cmds(base, 14);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_csb", {csb0, csb1}, 32'hFFFFFFFF);
    chk("t4_abort_ctl", {busy, done}, 2'b00);
    chk("t4_held_err", {fail, err_count}, {1'b1, 16'd1});
    exp_q.delete();
    stuck_addr = -1;
    repeat (3) @(negedge clk);
    go(3, 32'h3C3CC3C3, 4'd2, 1'b0);
    chk("t4_restart_clr", {fail, err_count}, 17'd0);
    wait_done(dc);
    chk("t4_restart_res", {done, fail, err_count}, {2'b10, 16'd0});
    chk("t4_queue", 64'(exp_q.size()), 64'd0);

    // start while busy is ignored
    base = cmd_cnt;
    go(3, 32'h12345678, 4'd3, 1'b0);
    repeat (4) @(negedge clk);
    chip_sel  = 4'd7;
    pattern   = 32'h0;
    last_addr = 16'd1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(dc);
    chk("t5_cmds", 64'(cmd_cnt - base), 64'd24);
    chk("t5_res", {done, fail, err_count}, {2'b10, 16'd0});

    // reset mid-M1
    base = cmd_cnt;
    go(3, 32'hFFFF0000, 4'd3, 1'b0);
    wait_cmds(base, 7);
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_rst_csb", {csb0, csb1}, 32'hFFFFFFFF);
    chk("t5_rst_ctl", {web0, wmask0, busy, done, fail}, 8'b1000_0000);
    chk("t5_rst_bus", {addr0, addr1, din0}, 64'h0);
    rstn = 1'b1;
    exp_q.delete();
    @(negedge clk);

    // port 1 for M3 on chip 4, fault visible only on port 1
    p1_addr = 1;
    base = cmd_cnt;
    go(3, 32'hA5A5A5A5, 4'd4, 1'b1);
    wait_done(dc);
    p1_addr = -1;
    chk("t6_cmds", 64'(cmd_cnt - base), 64'd24);
    chk("t6_err", {done, fail, err_count}, {2'b11, 16'd1});
    chk("t6_ff", {first_fail_addr, first_fail_data}, {16'd1, 32'hA5A5A585});
    chk("t6_queue", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
